// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg
//   Shared definitions for the handshaked pipeline stage register:
//   occupancy bus type, reset polarity, and the field constants that make up
//   a per-stage NOP payload (NOP aluop, NOP result select, no write-back).
package pipe_stage_reg_pkg;

    // Reset polarity shared with the rest of the CPU.
    localparam logic RstEnable = 1'b1;

    // NOP payload field constants.
    localparam logic [7:0]  EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [2:0]  EXE_RES_NOP  = 3'b000;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;

    // Canonical stage NOP: aluop, alusel, reg1, reg2, wd, wreg.
    localparam int STAGE_NOP_W = 8 + 3 + 32 + 32 + 5 + 1;
    localparam logic [STAGE_NOP_W-1:0] STAGE_NOP =
        {EXE_NOP_OP, EXE_RES_NOP, ZeroWord, ZeroWord, NOPRegAddr, WriteDisable};

    // Number of held entries.
    typedef logic [1:0] PipeOccBus;

    // Stage state; the encoding equals the occupancy count.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Handshaked pipeline stage register with an opaque payload, flush, and an
//   optional second (skid) entry that makes in_ready a pure function of
//   registered state.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active high
//   flush      synchronous kill of every held entry (drops same-cycle input)
//   in_valid   upstream offers in_data
//   in_ready   stage accepts this cycle
//   in_data    upstream payload
//   out_valid  out_data holds a live instruction
//   out_ready  downstream accepts out_data this cycle
//   out_data   payload to downstream, NOP_VALUE while out_valid=0
//   occupancy  number of held entries (0..2, max 1 when SKID=0)
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W    = 128,
    parameter bit                SKID      = 1'b1,
    parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(STAGE_NOP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output PipeOccBus         occupancy
);

    occ_e              state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_fire;
    logic              out_fire;
    logic              kill;

    assign kill      = (rst == RstEnable) || flush;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_valid = (state != OCC_EMPTY);
    assign occupancy = PipeOccBus'(state);

    // main_q is reloaded with NOP_VALUE whenever it empties, so it can drive
    // the output directly without a valid mux.
    assign out_data = main_q;

    generate
        if (SKID) begin : g_skid
            // Registered-only ready: no combinational path from out_ready.
            assign in_ready = (state != OCC_TWO);

            always_ff @(posedge clk) begin
                if (kill) begin
                    skid_q <= NOP_VALUE;
                end else if (state == OCC_ONE && in_fire && !out_fire) begin
                    skid_q <= in_data;
                end else if (state == OCC_TWO && out_fire) begin
                    skid_q <= NOP_VALUE;
                end
            end
        end else begin : g_noskid
            // Single entry: accept when empty or when the held beat leaves now.
            assign in_ready = ~out_valid | out_ready;
            assign skid_q   = NOP_VALUE;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (kill) begin
            state  <= OCC_EMPTY;
            main_q <= NOP_VALUE;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (in_fire) begin
                        main_q <= in_data;
                        state  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire && SKID) begin
                        // New beat parks in the skid entry (written above).
                        state <= OCC_TWO;
                    end else if (out_fire) begin
                        main_q <= NOP_VALUE;
                        state  <= OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    // in_ready is low here, so only a drain can happen.
                    if (out_fire) begin
                        main_q <= skid_q;
                        state  <= OCC_ONE;
                    end
                end
                default: begin
                    main_q <= NOP_VALUE;
                    state  <= OCC_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
`timescale 1ns/1ps
module tb_pipe_stage_reg;

    localparam logic [15:0] NOP = 16'hBEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;

    // SKID=1 instance
    logic        iv1 = 1'b0, or1 = 1'b0, ir1, ov1;
    logic [15:0] id1 = '0, od1;
    logic [1:0]  oc1;
    // SKID=0 instance
    logic        iv0 = 1'b0, or0 = 1'b0, ir0, ov0;
    logic [15:0] id0 = '0, od0;
    logic [1:0]  oc0;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: each stage is a bounded FIFO of accepted beats.
    logic [15:0] q1[$];
    logic [15:0] q0[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(16), .SKID(1'b1), .NOP_VALUE(NOP)) u_skid1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .occupancy(oc1));

    pipe_stage_reg #(.DATA_W(16), .SKID(1'b0), .NOP_VALUE(NOP)) u_skid0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0), .occupancy(oc0));

    // Acceptance rule: skid stage holds two beats, plain stage one beat
    // unless the held beat leaves in the same cycle.
    function automatic bit mrdy(input int sz, input bit skid, input bit ordy);
        return skid ? (sz < 2) : (sz == 0 || ordy);
    endfunction

    // Drive one DUT's inputs mid-cycle and let combinational outputs settle.
    task automatic drive(input bit sel, input bit iv, input logic [15:0] d,
                         input bit ordy, input bit fl);
        @(negedge clk);
        flush = fl;
        if (sel) begin iv1 = iv; id1 = d; or1 = ordy; end
        else     begin iv0 = iv; id0 = d; or0 = ordy; end
        #2;
    endtask

    // Clock edge plus model update from the inputs that were applied.
    task automatic advance();
        bit inf, outf;
        @(posedge clk);
        if (rst || flush) begin
            q1.delete();
            q0.delete();
        end else begin
            inf  = iv1 && mrdy(q1.size(), 1'b1, or1);
            outf = (q1.size() > 0) && or1;
            if (outf) void'(q1.pop_front());
            if (inf) q1.push_back(id1);
            inf  = iv0 && mrdy(q0.size(), 1'b0, or0);
            outf = (q0.size() > 0) && or0;
            if (outf) void'(q0.pop_front());
            if (inf) q0.push_back(id0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        iv1 = 1'b1; id1 = 16'h00A5; or1 = 1'b1;
        iv0 = 1'b1; id0 = 16'h00A5; or0 = 1'b1;
        advance();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #2;
            n_chk++; if (ov1 !== 1'b0) $display("FAIL reset_valid1 got %0b want 0", ov1); else n_pass++;
            n_chk++; if (od1 !== NOP) $display("FAIL reset_data1 got %h want %h", od1, NOP); else n_pass++;
            n_chk++; if (oc1 !== 2'd0) $display("FAIL reset_occ1 got %0d want 0", oc1); else n_pass++;
            n_chk++; if (ov0 !== 1'b0) $display("FAIL reset_valid0 got %0b want 0", ov0); else n_pass++;
            n_chk++; if (od0 !== NOP) $display("FAIL reset_data0 got %h want %h", od0, NOP); else n_pass++;
            advance();
        end
        @(negedge clk);
        rst = 1'b0; iv1 = 1'b0; iv0 = 1'b0; or1 = 1'b0; or0 = 1'b0;
        advance();
        @(negedge clk); #2;
        n_chk++; if (ov1 !== 1'b0) $display("FAIL post_reset_valid1 got %0b want 0", ov1); else n_pass++;
        n_chk++; if (oc1 !== 2'd0) $display("FAIL post_reset_occ1 got %0d want 0", oc1); else n_pass++;
        n_chk++; if (od1 !== NOP) $display("FAIL post_reset_data1 got %h want %h", od1, NOP); else n_pass++;
        n_chk++; if (ir1 !== 1'b1) $display("FAIL post_reset_ready1 got %0b want 1", ir1); else n_pass++;
        n_chk++; if (ir0 !== 1'b1) $display("FAIL post_reset_ready0 got %0b want 1", ir0); else n_pass++;
    endtask

    task automatic test_stream();
        logic        exp_v;
        logic [15:0] exp_d;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, i < 8, 16'(i + 1), 1'b1, 1'b0);
            exp_v = (i >= 1 && i <= 8);
            exp_d = exp_v ? 16'(i) : NOP;
            n_chk++; if (ir1 !== 1'b1) $display("FAIL stream_ready cyc %0d got %0b want 1", i, ir1); else n_pass++;
            n_chk++; if (ov1 !== exp_v) $display("FAIL stream_valid cyc %0d got %0b want %0b", i, ov1, exp_v); else n_pass++;
            n_chk++; if (od1 !== exp_d) $display("FAIL stream_data cyc %0d got %h want %h", i, od1, exp_d); else n_pass++;
            advance();
        end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 1'b1, 16'h0010, 1'b0, 1'b0);
        advance();
        drive(1'b1, 1'b1, 16'h0011, 1'b0, 1'b0);
        n_chk++; if (ir1 !== 1'b1) $display("FAIL bp_ready_one got %0b want 1", ir1); else n_pass++;
        n_chk++; if (oc1 !== 2'd1) $display("FAIL bp_occ_one got %0d want 1", oc1); else n_pass++;
        n_chk++; if (od1 !== 16'h0010) $display("FAIL bp_data_one got %h want 0010", od1); else n_pass++;
        advance();
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 1'b1, 16'h0012, 1'b0, 1'b0);
            n_chk++; if (ir1 !== 1'b0) $display("FAIL bp_ready_two got %0b want 0", ir1); else n_pass++;
            n_chk++; if (oc1 !== 2'd2) $display("FAIL bp_occ_two got %0d want 2", oc1); else n_pass++;
            n_chk++; if (od1 !== 16'h0010) $display("FAIL bp_data_two got %h want 0010", od1); else n_pass++;
            advance();
        end
        // Drain starts: ready stays low this cycle, head leaves.
        drive(1'b1, 1'b1, 16'h0012, 1'b1, 1'b0);
        n_chk++; if (ir1 !== 1'b0) $display("FAIL bp_ready_drain got %0b want 0", ir1); else n_pass++;
        n_chk++; if (od1 !== 16'h0010) $display("FAIL bp_out0 got %h want 0010", od1); else n_pass++;
        advance();
        drive(1'b1, 1'b1, 16'h0012, 1'b1, 1'b0);
        n_chk++; if (ir1 !== 1'b1) $display("FAIL bp_ready_after got %0b want 1", ir1); else n_pass++;
        n_chk++; if (od1 !== 16'h0011) $display("FAIL bp_out1 got %h want 0011", od1); else n_pass++;
        advance();
        drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        n_chk++; if (od1 !== 16'h0012) $display("FAIL bp_out2 got %h want 0012", od1); else n_pass++;
        n_chk++; if (ov1 !== 1'b1) $display("FAIL bp_valid2 got %0b want 1", ov1); else n_pass++;
        advance();
        drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        n_chk++; if (ov1 !== 1'b0) $display("FAIL bp_empty got %0b want 0", ov1); else n_pass++;
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b1, 16'h0030, 1'b0, 1'b0);
        advance();
        drive(1'b1, 1'b1, 16'h0031, 1'b0, 1'b0);
        advance();
        drive(1'b1, 1'b1, 16'h0020, 1'b1, 1'b1);
        n_chk++; if (oc1 !== 2'd2) $display("FAIL flush_pre_occ got %0d want 2", oc1); else n_pass++;
        advance();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
            n_chk++; if (oc1 !== 2'd0) $display("FAIL flush_occ cyc %0d got %0d want 0", c, oc1); else n_pass++;
            n_chk++; if (ov1 !== 1'b0) $display("FAIL flush_valid cyc %0d got %0b want 0", c, ov1); else n_pass++;
            n_chk++; if (od1 !== NOP) $display("FAIL flush_data cyc %0d got %h want %h", c, od1, NOP); else n_pass++;
            advance();
        end
    endtask

    task automatic test_skid0();
        logic [15:0] exp_d;
        iv1 = 1'b0; or1 = 1'b0;
        drive(1'b0, 1'b1, 16'h0040, 1'b1, 1'b0);
        advance();
        drive(1'b0, 1'b1, 16'h0041, 1'b0, 1'b0);
        n_chk++; if (ir0 !== 1'b0) $display("FAIL s0_ready_low got %0b want 0", ir0); else n_pass++;
        n_chk++; if (oc0 !== 2'd1) $display("FAIL s0_occ got %0d want 1", oc0); else n_pass++;
        n_chk++; if (od0 !== 16'h0040) $display("FAIL s0_data got %h want 0040", od0); else n_pass++;
        advance();
        drive(1'b0, 1'b1, 16'h0041, 1'b1, 1'b0);
        n_chk++; if (ir0 !== 1'b1) $display("FAIL s0_ready_high got %0b want 1", ir0); else n_pass++;
        advance();
        for (int c = 0; c < 16; c++) begin
            drive(1'b0, 1'b1, 16'(16'h0050 + c), c[0], 1'b0);
            exp_d = (q0.size() > 0) ? q0[0] : NOP;
            n_chk++; if (ir0 !== mrdy(q0.size(), 1'b0, or0)) $display("FAIL s0_tog_ready cyc %0d got %0b", c, ir0); else n_pass++;
            n_chk++; if (od0 !== exp_d) $display("FAIL s0_tog_data cyc %0d got %h want %h", c, od0, exp_d); else n_pass++;
            advance();
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        exp_d = (q0.size() > 0) ? q0[0] : NOP;
        n_chk++; if (od0 !== exp_d) $display("FAIL s0_tail_data got %h want %h", od0, exp_d); else n_pass++;
        advance();
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        n_chk++; if (oc0 !== 2'd0) $display("FAIL s0_drained got %0d want 0", oc0); else n_pass++;
    endtask

    task automatic test_random(input bit sel, input int cycles);
        int          sz;
        int          lim;
        logic        r, v, ordy;
        logic [15:0] d, exp_d;
        logic [1:0]  oc;
        iv1 = 1'b0; iv0 = 1'b0;
        lim = sel ? 2 : 1;
        for (int c = 0; c < cycles + 4; c++) begin
            if (c < cycles)
                drive(sel, $urandom_range(0, 99) < 60, 16'($urandom), $urandom_range(0, 99) < 55,
                      $urandom_range(0, 499) == 0);
            else
                drive(sel, 1'b0, 16'h0000, 1'b1, 1'b0);
            sz    = sel ? q1.size() : q0.size();
            exp_d = (sz == 0) ? NOP : (sel ? q1[0] : q0[0]);
            r     = sel ? ir1 : ir0;
            v     = sel ? ov1 : ov0;
            d     = sel ? od1 : od0;
            oc    = sel ? oc1 : oc0;
            ordy  = sel ? or1 : or0;
            n_chk++; if (r !== mrdy(sz, sel, ordy)) $display("FAIL rnd%0b_ready cyc %0d got %0b", sel, c, r); else n_pass++;
            n_chk++; if (v !== (sz != 0)) $display("FAIL rnd%0b_valid cyc %0d got %0b want %0b", sel, c, v, sz != 0); else n_pass++;
            n_chk++; if (d !== exp_d) $display("FAIL rnd%0b_data cyc %0d got %h want %h", sel, c, d, exp_d); else n_pass++;
            n_chk++; if (oc !== 2'(sz)) $display("FAIL rnd%0b_occ cyc %0d got %0d want %0d", sel, c, oc, sz); else n_pass++;
            n_chk++; if (int'(oc) > lim) $display("FAIL rnd%0b_occ_limit cyc %0d got %0d max %0d", sel, c, oc, lim); else n_pass++;
            advance();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_skid0();
        test_random(1'b1, 10000);
        test_random(1'b0, 10000);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline stage register that succeeds the fixed per-stage stall registers between CPU pipeline stages. It carries an opaque payload of configurable width. It replaces the global stall vector with a local valid/ready handshake, and adds a flush input. An optional two-entry skid buffer cuts the combinational ready path between stages. Instances sit between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Flush is driven by branch/exception control.

## Interface
- DATA_W, 128: payload width in bits; the stage packs aluop/alusel/operands/wd/wreg/etc. into it.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- NOP_VALUE, {DATA_W{1'b0}}: payload driven on out_data whenever out_valid is 0 (bubble); must encode NOP aluop, wreg disabled.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset (`RstEnable`).
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  upstream stage offers in_data.
- in_ready  output  1  stage can accept this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  out_data holds a live instruction.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  DATA_W  payload to downstream; NOP_VALUE when out_valid=0.
- occupancy  output  2  number of held entries (0..2; max 1 when SKID=0).

## Operation
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. A transfer occurs only on fire; in_data is ignored otherwise.
- Storage: main entry (drives out_data) and skid entry (SKID=1 only). States EMPTY/ONE/TWO = occupancy 0/1/2.
- EMPTY: in_fire -> ONE, main <= in_data.
- ONE:
  - in_fire & out_fire -> ONE, main <= in_data.
  - in_fire only -> TWO, skid <= in_data.
  - out_fire only -> EMPTY.
  - neither -> hold.
- TWO: in_ready=0. out_fire -> ONE, main <= skid. Otherwise hold.
- SKID=0: TWO unreachable. in_ready = ~out_valid | out_ready. ONE with in_fire & ~out_fire cannot occur.
- SKID=1: in_ready = (occupancy != 2). It is a pure function of registered state, with no path from out_ready.
- out_valid = (occupancy != 0). out_data = main when valid, else NOP_VALUE. The main register is itself loaded with NOP_VALUE on reset, flush and emptying, so no output mux is required.
- flush: next state EMPTY, main and skid <= NOP_VALUE. Flush overrides any same-cycle in_fire or out_fire; the input beat is dropped. Upstream must treat a beat accepted under flush as killed.
- rst: identical to flush and takes priority over all inputs. rst mid-transfer discards everything.
- Order is strictly FIFO; no reordering, duplication or loss except under flush/rst.

## Timing
- Reset values: out_valid=0, out_data=NOP_VALUE, occupancy=0. in_ready=1 in the cycle after reset deasserts (SKID=1); in_ready=1 combinationally once out_valid=0 (SKID=0).
- Latency: a beat accepted at edge N appears on out_data after edge N; minimum 1 cycle.
- Throughput: 1 beat/cycle sustained when out_ready is held high, for both SKID settings.
- Backpressure (SKID=1): when out_ready drops, one more beat is still accepted into skid, then in_ready falls at the next edge.
- The first cycle out_ready rises from TWO: main drains, skid moves to main, and in_ready=1 the following cycle.
- Flush effect is visible one edge after assertion (out_valid=0 after the edge).

## Structure
- Shared defines: `PipeOccBus` (1:0), and a per-stage NOP payload constant built from `EXE_NOP_OP`, `EXE_RES_NOP`, `NOPRegAddr`, `WriteDisable`, `ZeroWord`. Reuse `RstEnable`.
- Single module with no sub-module. The skid entry is generated only when SKID=1.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1, in_data=0xA5 -> out_valid=0, out_data=NOP_VALUE, occupancy=0 throughout and one cycle after.
- Streaming (SKID=1): out_ready=1, send 0x01..0x08 back-to-back -> 0x01..0x08 on out_data on consecutive cycles, each 1 cycle after acceptance, in_ready never low.
- Backpressure: ONE holding 0x10, out_ready=0, send 0x11, 0x12 -> 0x11 accepted, occupancy=2, in_ready=0, 0x12 held upstream. Then raise out_ready -> output 0x10, 0x11, 0x12 in order.
- Flush in TWO with simultaneous in_fire of 0x20 -> next cycle occupancy=0, out_data=NOP_VALUE, 0x20 never appears.
- SKID=0 instance: out_ready=0 while ONE -> in_ready=0 in the same cycle. Toggling out_ready gives a 1:1 in/out beat match with no loss.
- Random valid/ready (10k cycles, both SKID values) against a FIFO scoreboard -> no loss or reorder, and occupancy never exceeds its limit.
